// File: rtl/ov7670_emulator_pkg.sv
// Shared types and default timing for the OV7670 camera-bus emulator.
// Holds the FSM encoding, pattern-select codes, chroma constant and counter widths.
package ov7670_emulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VFRONT,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBACK
    } state_t;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_INDEX   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_EXT     = 2'd3
    } pattern_t;

    localparam logic [7:0] CHROMA = 8'h80;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_H_BLANK   = 144;
    localparam int DEF_VSYNC_LEN = 3;
    localparam int DEF_V_FRONT   = 17;
    localparam int DEF_V_BACK    = 10;

    localparam int BYTE_W = 11;
    localparam int LINE_W = 10;

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Luma source for the emulator: solid, pixel-index ramp, 8x8 checker or external byte.
module ov7670_pattern_gen
    import ov7670_emulator_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [BYTE_W-2:0] pixel,
    input  logic [LINE_W-1:0] line,
    input  logic [7:0]        SolidY,
    input  logic [7:0]        PixelIn,
    output logic [7:0]        Y
);

    logic w_unused;
    assign w_unused = ^{pixel[BYTE_W-2:8], line[LINE_W-1:4], line[2:0]};

    always_comb begin
        Y = '0;
        case (pattern_t'(sel))
            PAT_SOLID:   Y = SolidY;
            PAT_INDEX:   Y = pixel[7:0];
            PAT_CHECKER: Y = (pixel[3] ^ line[3]) ? 8'hFF : 8'h00;
            PAT_EXT:     Y = PixelIn;
            default:     Y = '0;
        endcase
    end

endmodule

// File: rtl/ov7670_emulator.sv
// OV7670-style YUV422 camera bus generator: PCLK = Clock/2, VSYNC/HREF/D framing.
// All bus state advances on "ticks" (PCLK 1->0) so data is stable at PCLK rise.
module ov7670_emulator
    import ov7670_emulator_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int H_BLANK   = DEF_H_BLANK,
    parameter int VSYNC_LEN = DEF_VSYNC_LEN,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [1:0]  PatternSel,
    input  logic [7:0]  SolidY,
    input  logic [7:0]  PixelIn,
    output logic        PCLK,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  D,
    output logic        PixelReq,
    output logic        FrameDone,
    output logic [15:0] FrameCount
);

    localparam logic [BYTE_W-1:0] LP_LAST   = BYTE_W'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [BYTE_W-1:0] ACT_LAST  = BYTE_W'(2 * H_ACTIVE - 1);
    localparam logic [BYTE_W-1:0] HBL_LAST  = BYTE_W'(H_BLANK - 1);
    localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VSYNC_LEN - 1);
    localparam logic [LINE_W-1:0] VF_LAST   = LINE_W'(V_FRONT - 1);
    localparam logic [LINE_W-1:0] VB_LAST   = LINE_W'(V_BACK - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);

    state_t              r_state;
    pattern_t            r_sel;
    logic [7:0]          r_solid;
    logic                r_pclk;
    logic                r_vsync;
    logic                r_href;
    logic [7:0]          r_d;
    logic                r_pix_req;
    logic                r_frame_done;
    logic [15:0]         r_frame_count;
    logic [BYTE_W-1:0]   r_byte;
    logic [LINE_W-1:0]   r_line;

    logic                w_tick;
    logic [LINE_W-1:0]   w_blank_last;
    logic                w_blank_end;
    logic                w_launch;
    logic [7:0]          w_luma;

    assign w_tick = r_pclk;

    // In blanking states r_byte counts ticks within a line period and r_line counts line periods.
    always_comb begin
        w_blank_last = VS_LAST;
        case (r_state)
            ST_VFRONT: w_blank_last = VF_LAST;
            ST_VBACK:  w_blank_last = VB_LAST;
            default:   w_blank_last = VS_LAST;
        endcase
    end

    assign w_blank_end = (r_byte == LP_LAST) && (r_line == w_blank_last);
    assign w_launch    = Enable && ((r_state == ST_IDLE) || (r_state == ST_VBACK && w_blank_end));

    // An even byte index means the next tick emits the luma of pixel r_byte/2.
    ov7670_pattern_gen u_pattern (
        .sel     (r_sel),
        .pixel   (r_byte[BYTE_W-1:1]),
        .line    (r_line),
        .SolidY  (r_solid),
        .PixelIn (PixelIn),
        .Y       (w_luma)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_sel         <= PAT_SOLID;
            r_solid       <= '0;
            r_pclk        <= 1'b0;
            r_vsync       <= 1'b0;
            r_href        <= 1'b0;
            r_d           <= '0;
            r_pix_req     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_byte        <= '0;
            r_line        <= '0;
        end else begin
            r_pclk       <= ~r_pclk;
            r_frame_done <= 1'b0;
            r_pix_req    <= !r_pclk && (r_state == ST_ACTIVE) && !r_byte[0] && (r_sel == PAT_EXT);

            if (w_tick) begin
                r_byte <= r_byte + BYTE_W'(1);
                case (r_state)
                    ST_IDLE: begin
                        r_byte <= '0;
                    end
                    ST_VSYNC, ST_VFRONT, ST_VBACK: begin
                        if (r_byte == LP_LAST) begin
                            r_byte <= '0;
                            r_line <= r_line + LINE_W'(1);
                        end
                        if (w_blank_end) begin
                            r_line <= '0;
                            if (r_state == ST_VSYNC) begin
                                r_state <= ST_VFRONT;
                                r_vsync <= 1'b0;
                            end else if (r_state == ST_VFRONT) begin
                                r_state <= ST_ACTIVE;
                                r_href  <= 1'b1;
                                r_d     <= CHROMA;
                            end else begin
                                r_state       <= ST_IDLE;
                                r_frame_done  <= 1'b1;
                                r_frame_count <= r_frame_count + 16'd1;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (r_byte == ACT_LAST) begin
                            r_state <= ST_HBLANK;
                            r_href  <= 1'b0;
                            r_d     <= '0;
                            r_byte  <= '0;
                        end else begin
                            r_d <= r_byte[0] ? CHROMA : w_luma;
                        end
                    end
                    ST_HBLANK: begin
                        if (r_byte == HBL_LAST) begin
                            r_byte <= '0;
                            if (r_line == LINE_LAST) begin
                                r_state <= ST_VBACK;
                                r_line  <= '0;
                            end else begin
                                r_state <= ST_ACTIVE;
                                r_href  <= 1'b1;
                                r_d     <= CHROMA;
                                r_line  <= r_line + LINE_W'(1);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase

                // Frame start from IDLE or straight after VBACK overrides the moves above.
                if (w_launch) begin
                    r_state <= ST_VSYNC;
                    r_vsync <= 1'b1;
                    r_byte  <= '0;
                    r_line  <= '0;
                    r_sel   <= pattern_t'(PatternSel);
                    r_solid <= SolidY;
                end
            end
        end
    end

    assign PCLK       = r_pclk;
    assign VSYNC      = r_vsync;
    assign HREF       = r_href;
    assign D          = r_d;
    assign PixelReq   = r_pix_req;
    assign FrameDone  = r_frame_done;
    assign FrameCount = r_frame_count;

endmodule
